// File: rtl/riscv_imm_stage_if.sv
// riscv_imm_stage_if -- handshake bundle for the immediate-decode stage.
//
// Parameters: XLEN (immediate width, 32 or 64), INST_LENGTH (instruction width, 32).
// Signals:
//   flush                      synchronous discard of all buffered entries
//   in_valid/in_ready/in_inst  upstream instruction handshake
//   out_valid/out_ready        downstream entry handshake
//   out_inst/out_imm/out_fmt/out_illegal  payload of the oldest entry
// Modports: slave = the stage itself, master = whoever drives/consumes it.
interface riscv_imm_stage_if #(
    parameter int XLEN        = 32,
    parameter int INST_LENGTH = 32
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [INST_LENGTH-1:0] in_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [INST_LENGTH-1:0] out_inst;
    logic [XLEN-1:0]        out_imm;
    logic [2:0]             out_fmt;
    logic                   out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/riscv_imm_stage.sv
// riscv_imm_stage -- RISC-V immediate decode stage with a 2-entry output FIFO.
//
// The instruction is decoded as it is accepted; format and extended immediate
// are stored alongside the instruction word, so an accepted input appears at
// the output exactly one cycle later.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous, active-high reset
//   io_bus  riscv_imm_stage_if.slave (flush, in_* handshake, out_* handshake/payload)
//
// Formats on out_fmt: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, X=7.
//
// Build option: define RISCV_IMM_ILLEGAL_EN to report unrecognised opcodes as
// X (out_fmt=7, out_illegal=1). Without it they decode as R and out_illegal is 0.
module riscv_imm_stage #(
    parameter int XLEN        = 32,   // 32 or 64
    parameter int INST_LENGTH = 32    // fixed at 32
) (
    input  logic              clk,
    input  logic              rst,
    riscv_imm_stage_if.slave  io_bus
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [INST_LENGTH-1:0] inst;
        logic [XLEN-1:0]        imm;
        logic [2:0]             fmt;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode at the input
    // ------------------------------------------------------------------
    logic [INST_LENGTH-1:0] w_inst;
    logic [2:0]             w_fmt;
    logic [31:0]            w_imm32;
    entry_t                 w_ent;

    assign w_inst = io_bus.in_inst;

    always_comb begin
        w_fmt = FMT_X;
        unique case (w_inst[6:0])
            7'b0110111, 7'b0010111:                       w_fmt = FMT_U;
            7'b1101111:                                   w_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: w_fmt = FMT_I;
            7'b0100011:                                   w_fmt = FMT_S;
            7'b1100011:                                   w_fmt = FMT_B;
            7'b0110011, 7'b0111011:                       w_fmt = FMT_R;
            7'b1110011:                                   w_fmt = w_inst[14] ? FMT_Z : FMT_I;
            default:                                      w_fmt = FMT_X;
        endcase
`ifndef RISCV_IMM_ILLEGAL_EN
        if (w_fmt == FMT_X) w_fmt = FMT_R;
`endif
    end

    // Every format fits in 32 bits with its sign at bit 31 (Z has a zero top
    // bit), so one signed widening to XLEN covers all cases.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            FMT_S: w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            FMT_B: w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                              w_inst[30:25], w_inst[11:8], 1'b0};
            FMT_J: w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
            FMT_U: w_imm32 = {w_inst[31:12], 12'b0};
            FMT_Z: w_imm32 = {27'b0, w_inst[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    assign w_ent.inst = w_inst;
    assign w_ent.imm  = XLEN'($signed(w_imm32));
    assign w_ent.fmt  = w_fmt;

    // ------------------------------------------------------------------
    // 2-entry FIFO: r_head is always the oldest entry, r_tail the second
    // ------------------------------------------------------------------
    state_t r_state;
    entry_t r_head;
    entry_t r_tail;
    logic   r_in_ready;
    logic   r_out_valid;
    logic   w_push;
    logic   w_pop;

    // in_ready comes from a register, so out_ready never reaches it combinationally.
    assign w_push = io_bus.in_valid & r_in_ready;
    assign w_pop  = r_out_valid & io_bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (io_bus.flush) begin
            // Beats any same-cycle push/pop; the input in this cycle is dropped.
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head      <= w_ent;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_tail     <= w_ent;
                            r_state    <= S_FULL;
                            r_in_ready <= 1'b0;
                        end
                        2'b01: begin
                            r_state     <= S_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                        2'b11: r_head <= w_ent;
                        default: ;
                    endcase
                end
                S_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_inst  = r_head.inst;
    assign io_bus.out_imm   = r_head.imm;
    assign io_bus.out_fmt   = r_head.fmt;
`ifdef RISCV_IMM_ILLEGAL_EN
    assign io_bus.out_illegal = r_out_valid & (r_head.fmt == FMT_X);
`else
    assign io_bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_imm_stage.sv
// tb_riscv_imm_stage -- directed bench for riscv_imm_stage, XLEN=32 and XLEN=64
// instances driven with identical stimulus.
module tb_riscv_imm_stage;

    logic        clk;
    logic        rst;
    logic        tb_flush;
    logic        tb_in_valid;
    logic [31:0] tb_in_inst;
    logic        tb_out_ready;

    int n_chk;
    int n_err;

    riscv_imm_stage_if #(.XLEN(32), .INST_LENGTH(32)) b32 ();
    riscv_imm_stage_if #(.XLEN(64), .INST_LENGTH(32)) b64 ();

    assign b32.flush     = tb_flush;
    assign b32.in_valid  = tb_in_valid;
    assign b32.in_inst   = tb_in_inst;
    assign b32.out_ready = tb_out_ready;
    assign b64.flush     = tb_flush;
    assign b64.in_valid  = tb_in_valid;
    assign b64.in_inst   = tb_in_inst;
    assign b64.out_ready = tb_out_ready;

    riscv_imm_stage #(.XLEN(32), .INST_LENGTH(32)) u_dut32 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b32.slave)
    );

    riscv_imm_stage #(.XLEN(64), .INST_LENGTH(32)) u_dut64 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty stage, check the entry one cycle later,
    // then let it drain.
    task automatic dec(input string tag, input logic [31:0] inst,
                       input logic [2:0] fmt, input logic [31:0] imm);
        logic [2:0]  efmt;
        logic        eill;
        logic [31:0] eimm;
        efmt = fmt;
        eill = 1'b0;
        eimm = imm;
`ifdef RISCV_IMM_ILLEGAL_EN
        if (fmt == 3'd7) eill = 1'b1;
`else
        if (fmt == 3'd7) efmt = 3'd0;
`endif
        tb_out_ready = 1'b1;
        tb_in_valid  = 1'b1;
        tb_in_inst   = inst;
        step();
        tb_in_valid  = 1'b0;
        chk({tag, ".vld"},   64'(b32.out_valid), 64'd1);
        chk({tag, ".inst"},  64'(b32.out_inst), 64'(inst));
        chk({tag, ".fmt"},   64'(b32.out_fmt), 64'(efmt));
        chk({tag, ".imm32"}, 64'(b32.out_imm), 64'(eimm));
        chk({tag, ".ill"},   64'(b32.out_illegal), 64'(eill));
        chk({tag, ".fmt64"}, 64'(b64.out_fmt), 64'(efmt));
        chk({tag, ".imm64"}, b64.out_imm, {{32{eimm[31]}}, eimm});
        step();
        chk({tag, ".drain"}, 64'(b32.out_valid), 64'd0);
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        rst          = 1'b1;
        tb_flush     = 1'b0;
        tb_in_valid  = 1'b1;        // must be ignored while in reset
        tb_in_inst   = 32'hFFF00093;
        tb_out_ready = 1'b0;

        // Reset state, with clock running and input offered.
        step();
        step();
        chk("rst.vld",   64'(b32.out_valid), 64'd0);
        chk("rst.rdy",   64'(b32.in_ready), 64'd1);
        chk("rst.imm",   64'(b32.out_imm), 64'd0);
        chk("rst.inst",  64'(b32.out_inst), 64'd0);
        chk("rst.fmt",   64'(b32.out_fmt), 64'd0);
        chk("rst.ill",   64'(b32.out_illegal), 64'd0);
        chk("rst.imm64", b64.out_imm, 64'd0);
        tb_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst.vld", 64'(b32.out_valid), 64'd0);

        // Decode vectors; expected values worked out by hand from the encodings.
        dec("addi",   32'hFFF00093, 3'd1, 32'hFFFFFFFF);
        dec("lui",    32'h80000537, 3'd4, 32'h80000000);
        dec("auipc",  32'hFFFFF097, 3'd4, 32'hFFFFF000);
        dec("jal8",   32'h0080006F, 3'd5, 32'h00000008);
        dec("jalm8",  32'hFF9FF0EF, 3'd5, 32'hFFFFFFF8);
        dec("beqm4",  32'hFE000EE3, 3'd3, 32'hFFFFFFFC);
        dec("csrrci", 32'h3000F073, 3'd6, 32'h00000001);
        dec("csrrw",  32'h34011073, 3'd1, 32'h00000340);
        dec("sw12",   32'h00112623, 3'd2, 32'h0000000C);
        dec("swm4",   32'hFE112E23, 3'd2, 32'hFFFFFFFC);
        dec("ldm8",   32'hFF813083, 3'd1, 32'hFFFFFFF8);
        dec("addiw",  32'h0010009B, 3'd1, 32'h00000001);
        dec("add",    32'h002081B3, 3'd0, 32'h00000000);
        dec("illeg",  32'h0000007F, 3'd7, 32'h00000000);

        // Back-pressure: A, B, C offered with out_ready low.
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_inst   = 32'hFFF00093;               // A
        step();
        chk("bp.rdy_one", 64'(b32.in_ready), 64'd1);
        tb_in_inst = 32'h002081B3;                 // B
        step();
        chk("bp.rdy_full", 64'(b32.in_ready), 64'd0);
        chk("bp.headA",    64'(b32.out_inst), 64'hFFF00093);
        tb_in_inst = 32'h00112623;                 // C, held upstream
        step();
        chk("bp.rdy_hold", 64'(b32.in_ready), 64'd0);
        chk("bp.holdA",    64'(b32.out_inst), 64'hFFF00093);
        chk("bp.holdimm",  64'(b32.out_imm), 64'hFFFFFFFF);
        chk("bp.vld",      64'(b32.out_valid), 64'd1);
        tb_out_ready = 1'b1;
        step();
        chk("bp.B",     64'(b32.out_inst), 64'h002081B3);
        chk("bp.rdy_B", 64'(b32.in_ready), 64'd1);
        step();                                    // C accepted, B popped
        tb_in_valid = 1'b0;
        chk("bp.C",     64'(b32.out_inst), 64'h00112623);
        chk("bp.C_fmt", 64'(b32.out_fmt), 64'd2);
        step();
        chk("bp.empty", 64'(b32.out_valid), 64'd0);

        // Streaming: one entry per cycle, no bubbles.
        begin
            logic [31:0] vec [4];
            vec[0] = 32'h0010009B;
            vec[1] = 32'h80000537;
            vec[2] = 32'hFE000EE3;
            vec[3] = 32'h3000F073;
            tb_out_ready = 1'b1;
            tb_in_valid  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tb_in_inst = vec[i];
                step();
                chk("stream.vld",  64'(b32.out_valid), 64'd1);
                chk("stream.rdy",  64'(b32.in_ready), 64'd1);
                chk("stream.inst", 64'(b32.out_inst), 64'(vec[i]));
            end
            tb_in_valid = 1'b0;
            step();
            chk("stream.end", 64'(b32.out_valid), 64'd0);
        end

        // Flush from FULL with a same-cycle input.
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_inst   = 32'hFFF00093;
        step();
        tb_in_inst   = 32'h002081B3;
        step();
        chk("fl.full", 64'(b32.in_ready), 64'd0);
        tb_flush     = 1'b1;
        tb_in_inst   = 32'h0080006F;
        tb_out_ready = 1'b1;
        step();
        tb_flush    = 1'b0;
        tb_in_valid = 1'b0;
        chk("fl.vld", 64'(b32.out_valid), 64'd0);
        chk("fl.rdy", 64'(b32.in_ready), 64'd1);
        step();
        chk("fl.nodrop_in", 64'(b32.out_valid), 64'd0);
        tb_in_valid = 1'b1;
        tb_in_inst  = 32'h3000F073;
        step();
        tb_in_valid = 1'b0;
        chk("fl.after", 64'(b32.out_inst), 64'h3000F073);
        step();

        // Reset mid-transfer drops everything; first input afterwards is first out.
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        tb_in_inst   = 32'hFFF00093;
        step();
        tb_in_inst   = 32'h002081B3;
        step();
        tb_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.vld",  64'(b32.out_valid), 64'd0);
        chk("mrst.rdy",  64'(b32.in_ready), 64'd1);
        chk("mrst.inst", 64'(b32.out_inst), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        tb_out_ready = 1'b1;
        tb_in_valid  = 1'b1;
        tb_in_inst   = 32'hFE112E23;
        step();
        tb_in_valid = 1'b0;
        chk("mrst.first", 64'(b32.out_inst), 64'hFE112E23);
        chk("mrst.fvld",  64'(b32.out_valid), 64'd1);
        step();
        chk("mrst.empty", 64'(b32.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
